// File: rtl/t_ff_bank.sv
// rtl/t_ff_bank.sv - parametrised bank of toggle flip-flops with counter, load and terminal-count modes
module t_ff_bank #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter bit                    SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  // w_all1[i] / w_all0[i]: bits 0..i-1 of q are all ones / all zeros
  logic [WIDTH:0]   w_all1;
  logic [WIDTH:0]   w_all0;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;
  logic             w_at_term;

  assign w_all1[0] = 1'b1;
  assign w_all0[0] = 1'b1;

  // T-cascade enables: each stage gates the next, like a ripple of T flops
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cascade
      assign w_all1[gi+1] = w_all1[gi] & r_q[gi];
      assign w_all0[gi+1] = w_all0[gi] & ~r_q[gi];
    end
  endgenerate

  // Per-bit toggle requests and terminal detection for the selected mode
  always_comb begin
    w_tog     = '0;
    w_at_term = 1'b0;
    case (mode)
      MODE_TOGGLE: w_tog = t;
      MODE_UP: begin
        w_tog     = w_all1[WIDTH-1:0];
        w_at_term = w_all1[WIDTH];
      end
      MODE_DOWN: begin
        w_tog     = w_all0[WIDTH-1:0];
        w_at_term = w_all0[WIDTH];
      end
      default: w_tog = '0;
    endcase
    // A saturating counter at its limit simply stops toggling
    if (SATURATE && w_at_term) begin
      w_tog = '0;
    end
  end

  // Next-state selection; load bypasses the toggle network entirely
  always_comb begin
    w_q_next  = r_q ^ w_tog;
    w_tc_next = w_at_term;
    if (mode == MODE_LOAD) begin
      w_q_next  = load_val;
      w_tc_next = 1'b0;
    end
  end

  // Bank state and terminal-count flag; reset dominates, disabled edges hold q and clear tc
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= RESET_VAL;
      r_tc <= 1'b0;
    end else if (enable) begin
      r_q  <= w_q_next;
      r_tc <= w_tc_next;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;
  assign tc   = r_tc;

endmodule

// File: doc/t_ff_bank.md
Name: t_ff_bank

Overview:
- Parametrised bank of WIDTH toggle flip-flops sharing one clock, reset and enable.
- Generalises the single-bit T flip-flop. Each bit can toggle independently, or the bank can act as a T-flop-cascade up/down counter or as a loadable register.
- Raises a registered terminal-count flag.
- Used as the building block for counters, dividers and bit-flag registers elsewhere in the design.

Parameters:
- WIDTH, 4, number of flip-flops in the bank (1..32).
- RESET_VAL, 0, value of q after reset (WIDTH bits).
- SATURATE, 0, 0 = counter wraps at terminal value; 1 = counter holds at terminal value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  1 = bank updates on this edge; 0 = q holds.
- mode  input  2  00 TOGGLE, 01 COUNT_UP, 10 COUNT_DOWN, 11 LOAD.
- t  input  WIDTH  per-bit toggle request (used in TOGGLE mode only).
- load_val  input  WIDTH  value loaded in LOAD mode.
- q  output  WIDTH  registered bank state.
- qbar  output  WIDTH  always ~q (combinational from q, no extra latency).
- tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset
  - Decided interface: one clock, clk; reset rst is synchronous and active-high.
  - On a rising clk with rst=1: q<=RESET_VAL and tc<=0, regardless of enable, mode, t or load_val.
  - rst has priority over every other input.
  - An operation in progress when rst is asserted is discarded; no partial update.
- Hold
  - With rst=0 and enable=0: q holds and tc<=0.
- Update (rst=0, enable=1), applied on the rising edge, visible on q the same edge (latency 1 from inputs):
  - TOGGLE: q[i] <= q[i] ^ t[i] for each bit; t=0 gives no change. tc<=0.
  - COUNT_UP: T-cascade semantics. Bit i toggles when bits 0..i-1 are all 1; bit 0 always toggles. Result equals q+1 mod 2^WIDTH.
    - Terminal value is all-ones.
    - If q is all-ones: SATURATE=0 gives q<=0; SATURATE=1 holds q. tc<=1 in both cases.
    - Otherwise tc<=0.
  - COUNT_DOWN: bit i toggles when bits 0..i-1 are all 0. Result equals q-1 mod 2^WIDTH.
    - Terminal value is 0.
    - If q is 0: SATURATE=0 gives q<=all-ones; SATURATE=1 holds q. tc<=1.
    - Otherwise tc<=0.
  - LOAD: q<=load_val; tc<=0. Loading the terminal value does not raise tc.
- tc rules
  - tc is high for exactly the cycle following an enabled count edge that started at the terminal value.
  - In saturate mode it re-asserts on every further enabled count edge at the limit, so it can stay high continuously.
- Mode changes
  - A mode change takes effect on the same edge; no pipeline state is carried between modes.
- Unused inputs
  - t is ignored outside TOGGLE; load_val is ignored outside LOAD.
- Width rules
  - No internal width growth; all arithmetic is modulo 2^WIDTH.
  - WIDTH=1 degenerates to a single T flip-flop. COUNT_UP and COUNT_DOWN both toggle bit 0, and tc follows the terminal rule (q=1 for up, q=0 for down).
- Timing constraint
  - qbar must never disagree with ~q, including during reset.

Test Plan (WIDTH=4, RESET_VAL=0 unless noted):
1. rst=1 for 1 edge, then enable=0 with varying t and mode for 3 edges -> q=0000, qbar=1111, tc=0 throughout.
2. TOGGLE, enable=1, t=1010 for 2 edges, then t=0000 -> q=1010, then 0000, then held at 0000; tc=0.
3. COUNT_UP, SATURATE=0, from q=1110 for 3 edges -> q=1111, 0000, 0001; tc high only in the cycle after the 1111->0000 edge. Repeat with SATURATE=1 -> q=1111, 1111, 1111; tc=0, 1, 1.
4. COUNT_DOWN, SATURATE=0, from LOAD of load_val=0001 -> q=0001, 0000, 1111; tc pulses once, after the 0000->1111 edge.
5. COUNT_UP running with q=0101, enable dropped for 2 edges then restored -> q holds 0101 and tc=0, then resumes 0110.
6. rst asserted mid-count with enable=1, mode=COUNT_UP, q=1111; repeat with RESET_VAL=1001 -> q=0000 (or 1001), tc=0 on the reset edge, no wrap pulse.
